// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - control and mux-drive signals of the scan sequencer
interface mux_scan_sequencer_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic [3:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         select;
  logic               enable;
  logic               busy;
  logic               sample_valid;
  logic               frame_done;

  modport master (
    output start, stop, ch_mask, dwell,
    input  select, enable, busy, sample_valid, frame_done
  );

  modport slave (
    input  start, stop, ch_mask, dwell,
    output select, enable, busy, sample_valid, frame_done
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - round-robin 4:1 mux scan controller with per-channel dwell
// Optional MUX_SCAN_ONESHOT_EN: stop after one full pass instead of scanning continuously.
module mux_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  mux_scan_sequencer_if.slave  bus
);
`ifdef MUX_SCAN_ONESHOT_EN
  localparam bit ONESHOT = 1'b1;
`else
  localparam bit ONESHOT = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SEEK, DWELL} state_t;

  state_t             state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         select_q, select_d;
  logic               enable_q, enable_d;

  logic       found;
  logic [1:0] hit;
  logic [1:0] idx;
  logic       upper_set;
  logic       sample_valid;
  logic       frame_done;

  // Walk the mask from ptr downward in offset so the lowest offset wins last.
  always_comb begin
    found = 1'b0;
    hit   = 2'd0;
    idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (bus.ch_mask[idx]) begin
        found = 1'b1;
        hit   = idx;
      end
    end
  end

  always_comb begin
    upper_set = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((2'(i) > select_q) && bus.ch_mask[i]) upper_set = 1'b1;
    end
  end

  assign sample_valid = (state_q == DWELL) && (cnt_q == '0);
  assign frame_done   = sample_valid && !upper_set;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    select_d = select_q;
    enable_d = enable_q;
    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (bus.start) state_d = SEEK;
      end
      SEEK: begin
        if (found) begin
          select_d = hit;
          enable_d = 1'b1;
          cnt_d    = bus.dwell;
          state_d  = DWELL;
        end else begin
          enable_d = 1'b0;
          ptr_d    = 2'd0;
          state_d  = IDLE;
        end
      end
      DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          enable_d = 1'b0;
          if (ONESHOT && frame_done) begin
            ptr_d   = 2'd0;
            state_d = IDLE;
          end else begin
            ptr_d   = select_q + 2'd1;
            state_d = SEEK;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
    endcase
    // stop overrides every transition; cnt and select deliberately keep their values
    if (bus.stop) begin
      state_d  = IDLE;
      ptr_d    = 2'd0;
      enable_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      select_q <= 2'd0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      select_q <= select_d;
      enable_q <= enable_d;
    end
  end

  assign bus.select       = select_q;
  assign bus.enable       = enable_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.sample_valid = sample_valid;
  assign bus.frame_done   = frame_done;
endmodule
